// File: rtl/lsu_seq_pkg.sv
// Shared state encoding and sizing constants for the LSU memory-op sequencer.
package lsu_seq_pkg;

  localparam logic [1:0] LSU_SEQ_IDLE = 2'd0;
  localparam logic [1:0] LSU_SEQ_LOAD = 2'd1;
  localparam logic [1:0] LSU_SEQ_REQ  = 2'd2;
  localparam logic [1:0] LSU_SEQ_DONE = 2'd3;

  localparam int unsigned LSU_DWORD_BYTES = 4;
  localparam int unsigned LSU_LANE_W      = 6;

  typedef enum logic [1:0] {
    StIdle = LSU_SEQ_IDLE,
    StLoad = LSU_SEQ_LOAD,
    StReq  = LSU_SEQ_REQ,
    StDone = LSU_SEQ_DONE
  } lsu_seq_state_e;

endpackage

// File: rtl/lsu_next_lane_finder.sv
// Combinational search for the lowest set mask bit at (inclusive) or above (exclusive) a start
// lane; found is low when no such bit exists.
module lsu_next_lane_finder
  import lsu_seq_pkg::*;
#(
  parameter int unsigned NUM_LANES = 64
) (
  input  logic [NUM_LANES-1:0]  mask,
  input  logic [LSU_LANE_W-1:0] start,
  input  logic                  inclusive,
  output logic [LSU_LANE_W-1:0] lane,
  output logic                  found
);

  // Scanning downwards leaves the lowest qualifying lane as the final assignment.
  always_comb begin
    lane  = '0;
    found = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(start)) || (inclusive && (i == int'(start))))) begin
        lane  = LSU_LANE_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_op_sequencer.sv
// Expands one latched LSU memory op into a serial stream of single-dword requests.
// Define LSU_SEQ_TIMEOUT_EN to add the mem_ack watchdog (TIMEOUT_CYCLES, sticky op_timeout).
module lsu_mem_op_sequencer
  import lsu_seq_pkg::*;
#(
  parameter int unsigned NUM_LANES = 64,
  parameter int unsigned ADDR_W    = 32
`ifdef LSU_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        op_rd,
  input  logic                        op_wr,
  input  logic                        op_gpr,
  input  logic [5:0]                  op_cnt,
  input  logic [1:0]                  op_depth,
  input  logic [ADDR_W-1:0]           scalar_base,
  input  logic [NUM_LANES*ADDR_W-1:0] lane_addr,
  input  logic [NUM_LANES-1:0]        exec_mask,
  output logic                        mem_req,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [5:0]                  mem_lane,
  output logic [5:0]                  mem_dword,
  input  logic                        mem_ack,
  output logic                        op_done,
  output logic                        op_timeout
);

  lsu_seq_state_e state_q, state_d;

  logic                        rd_q, wr_q, gpr_q;
  logic [5:0]                  cnt_q;
  logic [1:0]                  depth_q;
  logic [ADDR_W-1:0]           base_q;
  logic [NUM_LANES*ADDR_W-1:0] lanes_q;
  logic [NUM_LANES-1:0]        mask_q;

  logic [8:0]            total_q, total_d;
  logic [7:0]            w_q, w_d;
  logic [1:0]            d_q, d_d;
  logic [LSU_LANE_W-1:0] lane_q, lane_d;

  logic                  accept;
  logic [LSU_LANE_W-1:0] find_start, find_lane;
  logic                  find_incl, find_ok;
  logic [ADDR_W-1:0]     scalar_addr, vector_addr;

`ifdef LSU_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
`endif

  assign issue_ready = (state_q == StIdle);
  assign accept      = issue_valid & issue_ready;

  assign find_incl  = (state_q == StLoad);
  assign find_start = find_incl ? '0 : lane_q;

  lsu_next_lane_finder #(
    .NUM_LANES(NUM_LANES)
  ) u_finder (
    .mask     (mask_q),
    .start    (find_start),
    .inclusive(find_incl),
    .lane     (find_lane),
    .found    (find_ok)
  );

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    w_d     = w_q;
    d_d     = d_q;
    lane_d  = lane_q;
`ifdef LSU_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Ops with neither read nor write are accepted and retired without requests.
        if (issue_valid) state_d = (op_rd | op_wr) ? StLoad : StDone;
      end
      StLoad: begin
        if (gpr_q) begin
          d_d = '0;
          if (find_ok) begin
            lane_d  = find_lane;
            state_d = StReq;
          end else begin
            state_d = StDone;
          end
        end else begin
          total_d = (9'(cnt_q) + 9'd1) * (9'(depth_q) + 9'd1);
          w_d     = '0;
          lane_d  = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
`ifdef LSU_SEQ_TIMEOUT_EN
          wd_d = '0;
`endif
          if (!gpr_q) begin
            if ({1'b0, w_q} == total_q - 9'd1) state_d = StDone;
            else w_d = w_q + 8'd1;
          end else if (d_q < depth_q) begin
            d_d = d_q + 2'd1;
          end else begin
            d_d = '0;
            if (find_ok) lane_d = find_lane;
            else state_d = StDone;
          end
        end
`ifdef LSU_SEQ_TIMEOUT_EN
        else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          wd_d      = '0;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      gpr_q   <= 1'b0;
      cnt_q   <= '0;
      depth_q <= '0;
      base_q  <= '0;
      lanes_q <= '0;
      mask_q  <= '0;
      total_q <= '0;
      w_q     <= '0;
      d_q     <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      w_q     <= w_d;
      d_q     <= d_d;
      lane_q  <= lane_d;
      if (accept) begin
        rd_q    <= op_rd;
        wr_q    <= op_wr;
        gpr_q   <= op_gpr;
        cnt_q   <= op_cnt;
        depth_q <= op_depth;
        base_q  <= scalar_base;
        lanes_q <= lane_addr;
        mask_q  <= exec_mask;
      end
    end
  end

`ifdef LSU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign op_timeout = timeout_q;
`else
  assign op_timeout = 1'b0;
`endif

  assign scalar_addr = base_q + ADDR_W'(w_q) * ADDR_W'(LSU_DWORD_BYTES);
  assign vector_addr = lanes_q[lane_q*ADDR_W +: ADDR_W] + ADDR_W'(d_q) * ADDR_W'(LSU_DWORD_BYTES);

  assign mem_req   = (state_q == StReq);
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign op_done   = (state_q == StDone);
  assign mem_addr  = mem_req ? (gpr_q ? vector_addr : scalar_addr) : '0;
  assign mem_lane  = (mem_req && gpr_q) ? lane_q : '0;
  assign mem_dword = mem_req ? (gpr_q ? {4'b0000, d_q} : w_q[5:0]) : '0;

endmodule
